wb_stage: RTL and testbench

- Writeback stage feeding the integer register file's single write port (wen/waddr/wdata).
- Arbitrates between the single-cycle EXU result and the multi-cycle LSU load result, then registers the winner for one cycle of latency.
- Holds a per-register busy scoreboard that the issue logic queries for RAW/WAW hazards.

---
 rtl/wb_stage_if.sv | 70 +++++++
 rtl/wb_stage.sv | 114 +++++++++++
 tb/tb_wb_stage.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Bundle of every non-clock/reset signal of the writeback stage.
// master: the surrounding pipeline (EXU, LSU, issue, register file).
// slave:  the writeback stage itself.
// Define WB_BYPASS_EN to add the forwarding outputs rs1/rs2_fwd and rs1/rs2_fwd_data.
interface wb_stage_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  exu_valid;
  logic                  exu_ready;
  logic [ADDR_WIDTH-1:0] exu_rd;
  logic [DATA_WIDTH-1:0] exu_data;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;

  logic                  iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

`ifdef WB_BYPASS_EN
  logic                  rs1_fwd;
  logic                  rs2_fwd;
  logic [DATA_WIDTH-1:0] rs1_fwd_data;
  logic [DATA_WIDTH-1:0] rs2_fwd_data;

  modport master (
    output exu_valid, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  exu_ready, lsu_ready, rs1_busy, rs2_busy,
    input  rf_wen, rf_waddr, rf_wdata,
    input  rs1_fwd, rs2_fwd, rs1_fwd_data, rs2_fwd_data
  );

  modport slave (
    input  exu_valid, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output exu_ready, lsu_ready, rs1_busy, rs2_busy,
    output rf_wen, rf_waddr, rf_wdata,
    output rs1_fwd, rs2_fwd, rs1_fwd_data, rs2_fwd_data
  );
`else
  modport master (
    output exu_valid, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  exu_ready, lsu_ready, rs1_busy, rs2_busy,
    input  rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  exu_valid, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output exu_ready, lsu_ready, rs1_busy, rs2_busy,
    output rf_wen, rf_waddr, rf_wdata
  );
`endif
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: round-robin arbitration between EXU and LSU results,
// one registered write to the register file, and a per-register busy
// scoreboard for issue hazard checks.
// Optional macro WB_BYPASS_EN: forwards the in-flight write to rs1/rs2 and
// masks their busy flags while the forward is valid.
//
// state      | meaning
// GRANT_EXU  | last accepted transfer came from EXU (next tie goes to LSU)
// GRANT_LSU  | last accepted transfer came from LSU (next tie goes to EXU)
module wb_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  typedef enum logic {GRANT_EXU = 1'b0, GRANT_LSU = 1'b1} grant_t;

  grant_t                last_grant;
  logic                  exu_take;
  logic                  lsu_take;
  logic                  rf_wen_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;

  // Ready never looks at the output register: it drains every cycle.
  // A lone valid source wins; on a tie the source not granted last time wins.
  always_comb begin
    bus.exu_ready = !bus.lsu_valid || (bus.exu_valid && last_grant == GRANT_LSU);
    bus.lsu_ready = !bus.exu_valid || (bus.lsu_valid && last_grant == GRANT_EXU);
  end

  assign exu_take = bus.exu_valid && bus.exu_ready;
  assign lsu_take = bus.lsu_valid && bus.lsu_ready;

  // Register the winning result; writes to x0 complete the handshake but never assert wen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      last_grant <= GRANT_EXU;
    end else if (lsu_take) begin
      rf_wen_q   <= (bus.lsu_rd != '0);
      rf_waddr_q <= bus.lsu_rd;
      rf_wdata_q <= bus.lsu_data;
      last_grant <= GRANT_LSU;
    end else if (exu_take) begin
      rf_wen_q   <= (bus.exu_rd != '0);
      rf_waddr_q <= bus.exu_rd;
      rf_wdata_q <= bus.exu_data;
      last_grant <= GRANT_EXU;
    end else begin
      rf_wen_q   <= 1'b0;
    end
  end

  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

  // Scoreboard next state: the retiring write clears first so a same-edge issue re-sets it.
  always_comb begin
    busy_nxt = busy;
    if (rf_wen_q && busy[rf_waddr_q]) begin
      busy_nxt[rf_waddr_q] = 1'b0;
    end
    if (bus.iss_valid && bus.iss_rd != '0) begin
      busy_nxt[bus.iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

`ifdef WB_BYPASS_EN
  logic rs1_fwd_hit;
  logic rs2_fwd_hit;

  assign rs1_fwd_hit      = rf_wen_q && rf_waddr_q == bus.rs1 && bus.rs1 != '0;
  assign rs2_fwd_hit      = rf_wen_q && rf_waddr_q == bus.rs2 && bus.rs2 != '0;
  assign bus.rs1_fwd      = rs1_fwd_hit;
  assign bus.rs2_fwd      = rs2_fwd_hit;
  assign bus.rs1_fwd_data = rf_wdata_q;
  assign bus.rs2_fwd_data = rf_wdata_q;
  assign bus.rs1_busy     = busy[bus.rs1] && !rs1_fwd_hit;
  assign bus.rs2_busy     = busy[bus.rs2] && !rs2_fwd_hit;
`else
  assign bus.rs1_busy = busy[bus.rs1];
  assign bus.rs2_busy = busy[bus.rs2];
`endif

  // Issue must never target a busy rd, except one whose write retires at this very edge.
  always @(posedge clk) begin
    if (rst && bus.iss_valid && !(rf_wen_q && rf_waddr_q == bus.iss_rd)) begin
      assert (!busy[bus.iss_rd])
        else $error("wb_stage: issue to busy rd %0d", bus.iss_rd);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, compared against a register-level behavioural model.
module tb_wb_stage;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2 ** AW;

  logic clk = 1'b0;
  logic rst;

  wb_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: which registers await a write, who won the last tie, and the
  // write expected on the register-file port this cycle.
  bit            busy_m [NR];
  bit            lsu_won_last;
  logic          wen_m;
  logic [AW-1:0] waddr_m;
  logic [DW-1:0] wdata_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) busy_m[i] = 1'b0;
    lsu_won_last = 1'b0;
    wen_m   = 1'b0;
    waddr_m = '0;
    wdata_m = '0;
  endtask

  task automatic idle_inputs();
    bus.exu_valid = 1'b0; bus.exu_rd = '0; bus.exu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
  endtask

  // Called at posedge+1 with inputs already driven; checks combinational
  // outputs, crosses one clock edge, then checks the register-file port.
  task automatic step(input string tag);
    bit ev, lv, take_e, take_l;
    bit exp_b1, exp_b2;
    #1;
    ev = bus.exu_valid;
    lv = bus.lsu_valid;
    exp_b1 = busy_m[bus.rs1];
    exp_b2 = busy_m[bus.rs2];
`ifdef WB_BYPASS_EN
    begin
      bit f1, f2;
      f1 = wen_m && waddr_m == bus.rs1 && bus.rs1 != 0;
      f2 = wen_m && waddr_m == bus.rs2 && bus.rs2 != 0;
      chk({tag, ".rs1_fwd"}, bus.rs1_fwd, f1);
      chk({tag, ".rs2_fwd"}, bus.rs2_fwd, f2);
      if (f1) chk({tag, ".rs1_fwd_data"}, bus.rs1_fwd_data, wdata_m);
      if (f2) chk({tag, ".rs2_fwd_data"}, bus.rs2_fwd_data, wdata_m);
      exp_b1 = exp_b1 && !f1;
      exp_b2 = exp_b2 && !f2;
    end
`endif
    chk({tag, ".rs1_busy"}, bus.rs1_busy, exp_b1);
    chk({tag, ".rs2_busy"}, bus.rs2_busy, exp_b2);

    // Arbitration rules: alone wins; a tie alternates starting with LSU.
    take_e = 1'b0;
    take_l = 1'b0;
    if (ev && lv) begin
      if (lsu_won_last) take_e = 1'b1; else take_l = 1'b1;
      chk({tag, ".exu_ready"}, bus.exu_ready, take_e);
      chk({tag, ".lsu_ready"}, bus.lsu_ready, take_l);
    end else if (ev) begin
      take_e = 1'b1;
      chk({tag, ".exu_ready"}, bus.exu_ready, 1'b1);
    end else if (lv) begin
      take_l = 1'b1;
      chk({tag, ".lsu_ready"}, bus.lsu_ready, 1'b1);
    end else begin
      chk({tag, ".exu_ready_idle"}, bus.exu_ready, 1'b1);
      chk({tag, ".lsu_ready_idle"}, bus.lsu_ready, 1'b1);
    end

    // Scoreboard update: the write on the port now retires its register,
    // then any issue this cycle marks its destination pending.
    if (wen_m) busy_m[waddr_m] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != 0) busy_m[bus.iss_rd] = 1'b1;

    if (take_l) begin
      wen_m = (bus.lsu_rd != 0); waddr_m = bus.lsu_rd; wdata_m = bus.lsu_data;
      lsu_won_last = 1'b1;
    end else if (take_e) begin
      wen_m = (bus.exu_rd != 0); waddr_m = bus.exu_rd; wdata_m = bus.exu_data;
      lsu_won_last = 1'b0;
    end else begin
      wen_m = 1'b0;
    end

    @(posedge clk);
    #1;
    chk({tag, ".rf_wen"},   bus.rf_wen,   wen_m);
    chk({tag, ".rf_waddr"}, bus.rf_waddr, waddr_m);
    chk({tag, ".rf_wdata"}, bus.rf_wdata, wdata_m);
  endtask

  initial begin
    // Reset with random inputs on the bus
    rst = 1'b0;
    bus.exu_valid = 1'($urandom); bus.exu_rd = AW'($urandom); bus.exu_data = $urandom;
    bus.lsu_valid = 1'($urandom); bus.lsu_rd = AW'($urandom); bus.lsu_data = $urandom;
    bus.iss_valid = 1'($urandom); bus.iss_rd = AW'($urandom);
    bus.rs1 = '0; bus.rs2 = '0;
    model_reset();
    #2;
    chk("reset.rf_wen",   bus.rf_wen,   1'b0);
    chk("reset.rf_waddr", bus.rf_waddr, '0);
    chk("reset.rf_wdata", bus.rf_wdata, '0);
    @(posedge clk);
    #1;
    chk("reset_edge.rf_wen", bus.rf_wen, 1'b0);
    for (int i = 0; i < NR; i++) begin
      bus.rs1 = AW'(i);
      bus.rs2 = AW'(NR - 1 - i);
      #0.2;
      chk("reset.rs1_busy", bus.rs1_busy, 1'b0);
      chk("reset.rs2_busy", bus.rs2_busy, 1'b0);
    end
    idle_inputs();
    #1;
    chk("reset.exu_ready_idle", bus.exu_ready, 1'b1);
    chk("reset.lsu_ready_idle", bus.lsu_ready, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // First tie after reset goes to LSU, then EXU
    bus.rs1 = '0; bus.rs2 = '0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd3; bus.exu_data = 32'h11;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h22;
    #1;
    chk("tie0.lsu_ready", bus.lsu_ready, 1'b1);
    chk("tie0.exu_ready", bus.exu_ready, 1'b0);
    step("tie0");
    chk("tie0.waddr4", bus.rf_waddr, 5'd4);
    chk("tie0.wdata22", bus.rf_wdata, 32'h22);
    bus.lsu_valid = 1'b0;
    step("tie1");
    chk("tie1.wen", bus.rf_wen, 1'b1);
    chk("tie1.waddr3", bus.rf_waddr, 5'd3);
    chk("tie1.wdata11", bus.rf_wdata, 32'h11);
    idle_inputs();
    step("tie_drain");

    // Single write to x5 with scoreboard tracking
    bus.rs1 = 5'd5; bus.rs2 = 5'd6;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    step("sw_issue");
    chk("sw_issue.rs1_busy", bus.rs1_busy, 1'b1);
    bus.iss_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'hDEADBEEF;
    step("sw_accept");
    chk("sw_n1.wen", bus.rf_wen, 1'b1);
    chk("sw_n1.waddr", bus.rf_waddr, 5'd5);
    chk("sw_n1.wdata", bus.rf_wdata, 32'hDEADBEEF);
    idle_inputs();
`ifdef WB_BYPASS_EN
    chk("sw_n1.rs1_fwd", bus.rs1_fwd, 1'b1);
    chk("sw_n1.rs1_fwd_data", bus.rs1_fwd_data, 32'hDEADBEEF);
    chk("sw_n1.rs1_busy_bypass", bus.rs1_busy, 1'b0);
`else
    chk("sw_n1.rs1_busy", bus.rs1_busy, 1'b1);
`endif
    step("sw_n1");
    chk("sw_n2.rs1_busy", bus.rs1_busy, 1'b0);
    step("sw_n2");

    // x0 destination: accepted, never written, never busy
    bus.rs1 = '0;
    bus.exu_valid = 1'b1; bus.exu_rd = '0; bus.exu_data = 32'hFFFFFFFF;
    bus.iss_valid = 1'b1; bus.iss_rd = '0;
    #0.5;
    chk("x0.exu_ready", bus.exu_ready, 1'b1);
    step("x0");
    chk("x0.rf_wen", bus.rf_wen, 1'b0);
    idle_inputs();
    chk("x0.rs1_busy", bus.rs1_busy, 1'b0);
    step("x0_after");

    // Same-edge clear and set of x7: set wins
    bus.rs1 = 5'd7; bus.rs2 = 5'd0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    step("sc_issue");
    bus.iss_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_data = 32'h77;
    step("sc_accept");
    idle_inputs();
    chk("sc.rf_wen7", bus.rf_wen, 1'b1);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    step("sc_reissue");
    idle_inputs();
    chk("sc.busy7_kept", bus.rs1_busy, 1'b1);
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_data = 32'h78;
    step("sc_retire");
    idle_inputs();
    step("sc_drain");
    step("sc_clear");

    // Asynchronous reset in the middle of a write
    bus.rs1 = 5'd9; bus.rs2 = 5'd10;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    step("rm_issue9");
    bus.iss_rd = 5'd10;
    step("rm_issue10");
    bus.iss_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_data = 32'h99;
    step("rm_accept");
    idle_inputs();
    chk("rm.setup_wen", bus.rf_wen, 1'b1);
    chk("rm.setup_rs2_busy", bus.rs2_busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rm.rf_wen", bus.rf_wen, 1'b0);
    chk("rm.rf_waddr", bus.rf_waddr, '0);
    chk("rm.rs1_busy", bus.rs1_busy, 1'b0);
    chk("rm.rs2_busy", bus.rs2_busy, 1'b0);
    model_reset();
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      int r;
      bus.exu_valid = ($urandom_range(0, 99) < 55);
      bus.exu_rd    = AW'($urandom);
      bus.exu_data  = $urandom;
      bus.lsu_valid = ($urandom_range(0, 99) < 40);
      bus.lsu_rd    = AW'($urandom);
      bus.lsu_data  = $urandom;
      r = $urandom_range(0, NR - 1);
      bus.iss_valid = ($urandom_range(0, 3) == 0) && !busy_m[r];
      bus.iss_rd    = AW'(r);
      bus.rs1       = AW'($urandom);
      bus.rs2       = AW'($urandom);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
